// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
// Contents: frame data width, serial idle level, receiver FSM state enum,
// and an even-parity helper.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  // Even parity of a data word: 1 when the word has an odd number of ones.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous input.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset (flops load IDLE_LEVEL)
//   d   - asynchronous input
//   q   - synchronized output
module sync2
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Reset to the idle level so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= IDLE_LEVEL;
      q    <= IDLE_LEVEL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined).
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (>= 4)
// Ports:
//   clk        - system clock, rising edge
//   Rst        - synchronous active-high reset
//   Rx         - asynchronous serial line, idles high
//   Rx_byte    - last correctly received byte, held between frames
//   ready      - one-cycle pulse when Rx_byte is updated
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   parity_err - one-cycle pulse on parity mismatch (0 without parity)
// Optional feature macro: UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1250
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] Rx_byte,
  output logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_state_t       state, state_n;
  logic [CW-1:0]        baud_cnt, baud_cnt_n;
  logic [2:0]           bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] byte_n;
  logic                 ready_n, frame_err_n;
  logic [1:0]           settle, settle_n;
  logic                 armed, armed_n;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_bad_n;
  logic                 parity_err_n;
`endif

  sync2 u_sync (
    .clk (clk),
    .rst (Rst),
    .d   (Rx),
    .q   (rx_s)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      Rx_byte   <= '0;
      ready     <= 1'b0;
      frame_err <= 1'b0;
      settle    <= '0;
      armed     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      Rx_byte   <= byte_n;
      ready     <= ready_n;
      frame_err <= frame_err_n;
      settle    <= settle_n;
      armed     <= armed_n;
`ifdef UART_RX_PARITY_EN
      par_bad    <= par_bad_n;
      parity_err <= parity_err_n;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  // Next-state and output logic.
  always_comb begin
    state_n     = state;
    baud_cnt_n  = baud_cnt;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    byte_n      = Rx_byte;
    ready_n     = 1'b0;
    frame_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n    = par_bad;
    parity_err_n = 1'b0;
`endif

    // After reset the synchronizer holds its reset value for two cycles;
    // only arm once a genuine high level has come through, so a line that
    // was mid-frame at reset is not mistaken for a new start bit.
    settle_n = (settle == 2'd2) ? settle : settle + 2'd1;
    armed_n  = armed | ((settle == 2'd2) && (rx_s == IDLE_LEVEL));

    case (state)
      IDLE: begin
        baud_cnt_n = '0;
        if (armed && (rx_s != IDLE_LEVEL)) begin
          bit_cnt_n = '0;
          state_n   = START;
        end
      end

      START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_cnt_n = '0;
          state_n    = (rx_s != IDLE_LEVEL) ? DATA : IDLE;
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end

      DATA: begin
        if (baud_cnt == FULL_LAST) begin
          baud_cnt_n = '0;
          shift_n    = {rx_s, shift[DATA_BITS-1:1]};
          bit_cnt_n  = bit_cnt + 3'd1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_cnt == FULL_LAST) begin
          baud_cnt_n = '0;
          par_bad_n  = (rx_s != even_parity(shift));
          state_n    = STOP;
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end
`endif

      STOP: begin
        if (baud_cnt == FULL_LAST) begin
          baud_cnt_n = '0;
          if (rx_s == IDLE_LEVEL) begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            if (par_bad) begin
              parity_err_n = 1'b1;
            end else begin
              byte_n  = shift;
              ready_n = 1'b1;
            end
`else
            byte_n  = shift;
            ready_n = 1'b1;
`endif
          end else begin
            frame_err_n = 1'b1;
            state_n     = WAIT_HIGH;
          end
        end else begin
          baud_cnt_n = baud_cnt + CW'(1);
        end
      end

      WAIT_HIGH: begin
        baud_cnt_n = '0;
        if (rx_s == IDLE_LEVEL) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n    = IDLE;
        baud_cnt_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed, table-driven bench for uart_rx at CLKS_PER_BIT=8.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int unsigned CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NSTOP = 10;
`else
  localparam int NSTOP = 9;
`endif
  // Start edge (cycle 0) to ready pulse.
  localparam int LAT = 2 + CPB / 2 + NSTOP * CPB;

  logic       clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Rx  = 1'b1;
  logic [7:0] Rx_byte;
  logic       ready, frame_err, parity_err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .Rst        (Rst),
    .Rx         (Rx),
    .Rx_byte    (Rx_byte),
    .ready      (ready),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse monitor, sampled on the falling edge.
  int         n_ready = 0, n_ferr = 0, n_perr = 0, n_overlap = 0, n_long = 0;
  int         ready_q[$];
  logic [7:0] byte_q[$];
  logic       prev_ready = 1'b0;

  always @(negedge clk) begin
    if (ready) begin
      n_ready++;
      ready_q.push_back(cyc);
      byte_q.push_back(Rx_byte);
    end
    if (frame_err) n_ferr++;
    if (parity_err) n_perr++;
    if ((int'(ready) + int'(frame_err) + int'(parity_err)) > 1) n_overlap++;
    if (ready && prev_ready) n_long++;
    prev_ready = ready;
  end

  task automatic clear_mon();
    n_ready = 0;
    n_ferr  = 0;
    n_perr  = 0;
    ready_q.delete();
    byte_q.delete();
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive nb bits LSB first, one bit per CPB cycles; s = cycle 0 of the start edge.
  task automatic send_raw(input logic [10:0] bits, input int nb, output int s);
    s = cyc + 1;
    for (int i = 0; i < nb; i++) begin
      Rx = bits[i];
      tick(CPB);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, output int s);
`ifdef UART_RX_PARITY_EN
    send_raw({stop, ^d, d, 1'b0}, 11, s);
`else
    send_raw({1'b0, stop, d, 1'b0}, 10, s);
`endif
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         hold_low;
    int         exp_ready;
    int         exp_ferr;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int s, s2;

    vecs[0] = '{8'h41, 1'b1, 0,  1, 0, 8'h41};
    vecs[1] = '{8'h00, 1'b1, 0,  1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0,  1, 0, 8'hFF};
    vecs[3] = '{8'h7E, 1'b0, 40, 0, 1, 8'hFF};
    vecs[4] = '{8'hC3, 1'b1, 0,  1, 0, 8'hC3};

    // Power-on reset.
    tick(3);
    check("rst_byte", 32'(Rx_byte), 32'h00);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_perr", 32'(parity_err), 32'd0);
    Rst = 1'b0;
    tick(5);

    // Table of single frames.
    for (int i = 0; i < 5; i++) begin
      clear_mon();
      send_frame(vecs[i].data, vecs[i].stop, s);
      if (vecs[i].hold_low > 0) tick(vecs[i].hold_low);
      Rx = 1'b1;
      tick(2 * CPB);
      check($sformatf("v%0d_ready_cnt", i), 32'(n_ready), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d_ferr_cnt", i), 32'(n_ferr), 32'(vecs[i].exp_ferr));
      check($sformatf("v%0d_perr_cnt", i), 32'(n_perr), 32'd0);
      check($sformatf("v%0d_byte", i), 32'(Rx_byte), 32'(vecs[i].exp_byte));
      if (ready_q.size() > 0)
        check($sformatf("v%0d_ready_cyc", i), 32'(ready_q[0]), 32'(s + LAT));
    end

    // Back-to-back frames with no idle gap.
    clear_mon();
    send_frame(8'h5A, 1'b1, s);
    send_frame(8'hA5, 1'b1, s2);
    tick(2 * CPB);
    check("b2b_ready_cnt", 32'(n_ready), 32'd2);
    if (ready_q.size() == 2) begin
      check("b2b_first_cyc", 32'(ready_q[0]), 32'(s + LAT));
      check("b2b_gap", 32'(ready_q[1] - ready_q[0]), 32'((NSTOP + 1) * CPB));
      check("b2b_byte0", 32'(byte_q[0]), 32'h5A);
      check("b2b_byte1", 32'(byte_q[1]), 32'hA5);
    end

    // Short low glitch on an idle line, then a real frame.
    clear_mon();
    Rx = 1'b0;
    tick(2);
    Rx = 1'b1;
    tick(3 * CPB);
    check("glitch_pulses", 32'(n_ready + n_ferr + n_perr), 32'd0);
    check("glitch_idle", 32'(dut.state), 32'(IDLE));
    check("glitch_byte", 32'(Rx_byte), 32'hA5);
    send_frame(8'h33, 1'b1, s);
    tick(2 * CPB);
    check("post_glitch_ready", 32'(n_ready), 32'd1);
    check("post_glitch_byte", 32'(Rx_byte), 32'h33);

    // Reset for 3 cycles inside the start bit of a 0x00 frame.
    clear_mon();
    Rx = 1'b0;
    tick(2);
    Rst = 1'b1;
    tick(3);
    Rst = 1'b0;
    tick(1);
    check("midrst_byte", 32'(Rx_byte), 32'h00);
    check("midrst_outs", 32'({ready, frame_err, parity_err}), 32'd0);
    tick(8 * CPB);
    Rx = 1'b1;
    tick(12 * CPB);
    check("midrst_ready", 32'(n_ready), 32'd0);
    check("midrst_ferr", 32'(n_ferr), 32'd0);
    check("midrst_byte_after", 32'(Rx_byte), 32'h00);

`ifdef UART_RX_PARITY_EN
    // 0x03 has even parity 0: a parity bit of 1 is a mismatch.
    clear_mon();
    send_raw({1'b1, 1'b1, 8'h03, 1'b0}, 11, s);
    tick(2 * CPB);
    check("par_bad_perr", 32'(n_perr), 32'd1);
    check("par_bad_ready", 32'(n_ready), 32'd0);
    check("par_bad_byte", 32'(Rx_byte), 32'h00);
    clear_mon();
    send_raw({1'b1, 1'b0, 8'h03, 1'b0}, 11, s);
    tick(2 * CPB);
    check("par_ok_perr", 32'(n_perr), 32'd0);
    check("par_ok_ready", 32'(n_ready), 32'd1);
    check("par_ok_byte", 32'(Rx_byte), 32'h03);
`endif

    check("pulse_overlap", 32'(n_overlap), 32'd0);
    check("ready_width", 32'(n_long), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
